mem_stage_seq: RTL and testbench
================================

Name: mem_stage_seq

Overview:
- MEM-stage sequencer for the pipelined LC-3b datapath.
- Consumes the memory fields of the decoded control word (mem_read, mem_write, is_ldi, is_sti, mem_byte_enable) plus the EX-computed address and store data.
- Performs the handshake with the data-memory port (read/write held until resp) and stalls the pipeline until the access completes.
- Sequences the two-access indirect instructions (LDI, STI) and returns load data to writeback.

Parameters:
- WIDTH, 16, data and address width in bits (LC-3b word).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  the MEM-stage instruction is valid.
- req_mem_read  input  1  control word mem_read.
- req_mem_write  input  1  control word mem_write.
- req_is_ldi  input  1  control word is_ldi.
- req_is_sti  input  1  control word is_sti.
- req_byte_enable  input  2  control word mem_byte_enable.
- req_address  input  WIDTH  effective address from EX.
- req_wdata  input  WIDTH  store data, already byte-lane aligned.
- dmem_read  output  1  read strobe to data memory.
- dmem_write  output  1  write strobe to data memory.
- dmem_address  output  WIDTH  word-aligned access address.
- dmem_wdata  output  WIDTH  write data.
- dmem_byte_enable  output  2  write lane enables.
- dmem_resp  input  1  one-cycle completion pulse from data memory.
- dmem_rdata  input  WIDTH  read data; valid when dmem_resp=1.
- mem_stall  output  1  holds IF..MEM pipeline registers.
- mem_done  output  1  one-cycle pulse when the access completes.
- mem_rdata  output  WIDTH  final load data (LDR/LDB/LDI); held until the next completion.

Behaviour:
- Request qualification: req_is_mem = req_valid & (req_mem_read | req_mem_write | req_is_ldi | req_is_sti).
- Request class priority: is_sti > is_ldi > mem_write > mem_read.
- States: IDLE, ACC1, ACC2, DONE. Async reset forces IDLE.
- Reset values: all registered fields and mem_rdata = 0; every output 0.
- IDLE:
  - If req_is_mem, capture class, {req_address[15:1],0}, req_wdata and req_byte_enable into internal regs; go to ACC1.
  - mem_stall = req_is_mem combinationally, so the stall begins in the acceptance cycle.
- ACC1:
  - Drive dmem_address = captured address.
  - Plain write: dmem_write=1, dmem_byte_enable = captured enable, dmem_wdata = captured data.
  - Read, LDI, STI: dmem_read=1 (STI's first access is a pointer read), dmem_byte_enable=2'b11.
  - Hold all dmem outputs stable until dmem_resp.
  - On resp, plain read: mem_rdata <= dmem_rdata; go to DONE.
  - On resp, plain write: go to DONE.
  - On resp, LDI/STI: pointer <= {dmem_rdata[15:1],0}; go to ACC2.
- ACC2:
  - dmem_address = pointer, dmem_byte_enable=2'b11.
  - LDI: dmem_read=1. On resp, mem_rdata <= dmem_rdata; go to DONE.
  - STI: dmem_write=1, dmem_wdata = captured wdata. On resp, go to DONE.
- DONE:
  - mem_done=1, mem_stall=0; the pipeline advances on this edge.
  - Unconditionally go to IDLE. A request present in DONE is not accepted until the IDLE cycle.
- mem_stall=1 in ACC1 and ACC2; 0 in DONE.
- Strobe rules: dmem_read and dmem_write are never both 1; both are 0 in IDLE and DONE.
- Latency, single access with a memory response N cycles after strobe assertion (N>=1): acceptance cycle + N cycles in ACC1 + 1 DONE cycle, i.e. stall for N+1 cycles.
- Latency, LDI/STI: two memory latencies plus the DONE cycle.
- Boundary conditions:
  - dmem_resp in IDLE or DONE is ignored and no state changes.
  - Request inputs changing while in ACC1/ACC2 are ignored, because the captured copy is used.
  - req_valid=0 with memory bits set is not a request.
  - Pointer read returning an odd address: bit 0 is cleared.
  - Reset asserted mid-access: state goes to IDLE and strobes drop in the same cycle (asynchronous); no completion is reported.
  - mem_rdata retains its last value through non-load completions.

Test Plan:
- LDR at x1003, resp after 2 cycles with rdata=xBEEF -> dmem_address=x1002, dmem_read high 2 cycles, mem_stall 3 cycles, mem_done pulse, mem_rdata=xBEEF.
- STB with be=2'b10, addr x2001, wdata=xAB00 -> dmem_write=1, byte_enable=2'b10, address x2000, wdata xAB00; mem_rdata unchanged.
- LDI at x3000, first rdata=x4001, second rdata=x1234 -> second access reads x4000, mem_rdata=x1234, exactly 2 read handshakes.
- STI at x3000, pointer x5000, wdata=x00FF -> read x3000, then write x5000 with enable 2'b11 and wdata x00FF.
- Spurious dmem_resp in IDLE, plus a non-memory instruction (ADD: all memory bits 0) -> no strobes, no stall, no done.
- rst pulsed mid-ACC2 of an LDI -> strobes 0 immediately, state IDLE, mem_rdata=0; a new LDR afterwards completes normally.

Source files
------------

// File: rtl/mem_stage_seq.sv
// MEM-stage sequencer for the pipelined LC-3b datapath: runs the data-memory handshake,
// stalls the pipeline while an access is outstanding and chains the two accesses of LDI/STI.
module mem_stage_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_mem_read,
  input  logic             req_mem_write,
  input  logic             req_is_ldi,
  input  logic             req_is_sti,
  input  logic [1:0]       req_byte_enable,
  input  logic [WIDTH-1:0] req_address,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [WIDTH-1:0] dmem_address,
  output logic [WIDTH-1:0] dmem_wdata,
  output logic [1:0]       dmem_byte_enable,
  input  logic             dmem_resp,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic             mem_stall,
  output logic             mem_done,
  output logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StAcc1, StAcc2, StDone} state_e;
  typedef enum logic [1:0] {ClsRead, ClsWrite, ClsLdi, ClsSti} cls_e;

  state_e           state_q;
  cls_e             cls_q;
  cls_e             req_cls;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [1:0]       be_q;
  logic [WIDTH-1:0] ptr_q;
  logic [WIDTH-1:0] rdata_q;
  logic             req_is_mem;

  assign req_is_mem = req_valid & (req_mem_read | req_mem_write | req_is_ldi | req_is_sti);

  always_comb begin
    req_cls = ClsRead;
    if (req_is_sti)         req_cls = ClsSti;
    else if (req_is_ldi)    req_cls = ClsLdi;
    else if (req_mem_write) req_cls = ClsWrite;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cls_q   <= ClsRead;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      ptr_q   <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_is_mem) begin
            cls_q   <= req_cls;
            addr_q  <= {req_address[WIDTH-1:1], 1'b0};
            wdata_q <= req_wdata;
            be_q    <= req_byte_enable;
            state_q <= StAcc1;
          end
        end
        StAcc1: begin
          if (dmem_resp) begin
            unique case (cls_q)
              ClsRead: begin
                rdata_q <= dmem_rdata;
                state_q <= StDone;
              end
              ClsWrite: state_q <= StDone;
              // LDI and STI: first access fetched the pointer
              default: begin
                ptr_q   <= {dmem_rdata[WIDTH-1:1], 1'b0};
                state_q <= StAcc2;
              end
            endcase
          end
        end
        StAcc2: begin
          if (dmem_resp) begin
            if (cls_q == ClsLdi) rdata_q <= dmem_rdata;
            state_q <= StDone;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decode straight from state so an async reset drops the strobes at once.
  always_comb begin
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_address     = '0;
    dmem_wdata       = '0;
    dmem_byte_enable = 2'b00;
    mem_stall        = 1'b0;
    mem_done         = 1'b0;
    unique case (state_q)
      StIdle: mem_stall = req_is_mem;
      StAcc1: begin
        mem_stall    = 1'b1;
        dmem_address = addr_q;
        if (cls_q == ClsWrite) begin
          dmem_write       = 1'b1;
          dmem_wdata       = wdata_q;
          dmem_byte_enable = be_q;
        end else begin
          dmem_read        = 1'b1;
          dmem_byte_enable = 2'b11;
        end
      end
      StAcc2: begin
        mem_stall        = 1'b1;
        dmem_address     = ptr_q;
        dmem_byte_enable = 2'b11;
        if (cls_q == ClsSti) begin
          dmem_write = 1'b1;
          dmem_wdata = wdata_q;
        end else begin
          dmem_read = 1'b1;
        end
      end
      StDone: mem_done = 1'b1;
      default: ;
    endcase
  end

  assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_mem_stage_seq.sv
// Self-checking bench for mem_stage_seq: directed plan items plus randomized transactions
// compared against an access-list model of each instruction class.
module tb_mem_stage_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_mem_read, req_mem_write, req_is_ldi, req_is_sti;
  logic [1:0]  req_byte_enable;
  logic [15:0] req_address, req_wdata;
  logic        dmem_read, dmem_write;
  logic [15:0] dmem_address, dmem_wdata;
  logic [1:0]  dmem_byte_enable;
  logic        dmem_resp;
  logic [15:0] dmem_rdata;
  logic        mem_stall, mem_done;
  logic [15:0] mem_rdata;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_rdata;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    int          lat;
    logic [15:0] rdata;
  } acc_t;

  mem_stage_seq #(.WIDTH(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_mem_read     (req_mem_read),
    .req_mem_write    (req_mem_write),
    .req_is_ldi       (req_is_ldi),
    .req_is_sti       (req_is_sti),
    .req_byte_enable  (req_byte_enable),
    .req_address      (req_address),
    .req_wdata        (req_wdata),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_address     (dmem_address),
    .dmem_wdata       (dmem_wdata),
    .dmem_byte_enable (dmem_byte_enable),
    .dmem_resp        (dmem_resp),
    .dmem_rdata       (dmem_rdata),
    .mem_stall        (mem_stall),
    .mem_done         (mem_done),
    .mem_rdata        (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag, input logic stall_exp);
    chk({tag, ".read"}, 32'(dmem_read), 32'd0);
    chk({tag, ".write"}, 32'(dmem_write), 32'd0);
    chk({tag, ".stall"}, 32'(mem_stall), 32'(stall_exp));
    chk({tag, ".done"}, 32'(mem_done), 32'd0);
  endtask

  task automatic scramble_req();
    req_valid       = 1'($urandom);
    req_mem_read    = 1'($urandom);
    req_mem_write   = 1'($urandom);
    req_is_ldi      = 1'($urandom);
    req_is_sti      = 1'($urandom);
    req_byte_enable = 2'($urandom);
    req_address     = 16'($urandom);
    req_wdata       = 16'($urandom);
  endtask

  // kind: 0 load, 1 store, 2 LDI, 3 STI. Lower-priority bits are set at random.
  task automatic drive_req(input int kind, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [1:0] be);
    req_valid       = 1'b1;
    req_is_sti      = (kind == 3);
    req_is_ldi      = (kind == 2) || (kind == 3 && 1'($urandom));
    req_mem_write   = (kind == 1) || (kind >= 2 && 1'($urandom));
    req_mem_read    = (kind == 0) || 1'($urandom);
    req_byte_enable = be;
    req_address     = addr;
    req_wdata       = wdata;
  endtask

  task automatic run_txn(input string nm, input int kind, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [1:0] be,
                         input int lat1, input int lat2,
                         input logic [15:0] rd1, input logic [15:0] rd2);
    acc_t q[$];
    acc_t a;
    a = '{wr: (kind == 1), addr: addr & 16'hFFFE, be: (kind == 1) ? be : 2'b11,
          wdata: wdata, lat: lat1, rdata: rd1};
    q.push_back(a);
    if (kind >= 2) begin
      a = '{wr: (kind == 3), addr: rd1 & 16'hFFFE, be: 2'b11, wdata: wdata, lat: lat2,
            rdata: rd2};
      q.push_back(a);
    end
    if (kind == 0) exp_rdata = rd1;
    if (kind == 2) exp_rdata = rd2;

    @(negedge clk);
    dmem_resp = 1'b0;
    drive_req(kind, addr, wdata, be);
    #1;
    chk({nm, ".accept.stall"}, 32'(mem_stall), 32'd1);
    chk({nm, ".accept.read"}, 32'(dmem_read), 32'd0);
    chk({nm, ".accept.write"}, 32'(dmem_write), 32'd0);
    @(posedge clk);
    #1 scramble_req();
    foreach (q[i]) begin
      for (int c = 1; c <= q[i].lat; c++) begin
        @(negedge clk);
        dmem_resp  = (c == q[i].lat);
        dmem_rdata = (c == q[i].lat) ? q[i].rdata : 16'($urandom);
        scramble_req();
        #1;
        chk($sformatf("%s.a%0d.c%0d.read", nm, i, c), 32'(dmem_read), 32'(!q[i].wr));
        chk($sformatf("%s.a%0d.c%0d.write", nm, i, c), 32'(dmem_write), 32'(q[i].wr));
        chk($sformatf("%s.a%0d.c%0d.addr", nm, i, c), 32'(dmem_address), 32'(q[i].addr));
        chk($sformatf("%s.a%0d.c%0d.be", nm, i, c), 32'(dmem_byte_enable), 32'(q[i].be));
        if (q[i].wr)
          chk($sformatf("%s.a%0d.c%0d.wdata", nm, i, c), 32'(dmem_wdata), 32'(q[i].wdata));
        chk($sformatf("%s.a%0d.c%0d.stall", nm, i, c), 32'(mem_stall), 32'd1);
        chk($sformatf("%s.a%0d.c%0d.done", nm, i, c), 32'(mem_done), 32'd0);
        @(posedge clk);
        #1 dmem_resp = 1'b0;
      end
    end
    @(negedge clk);
    // Stray response and a pending request in DONE must both be ignored.
    dmem_resp = 1'($urandom);
    drive_req(0, 16'($urandom), 16'h0, 2'b11);
    #1;
    chk({nm, ".done.pulse"}, 32'(mem_done), 32'd1);
    chk({nm, ".done.stall"}, 32'(mem_stall), 32'd0);
    chk({nm, ".done.read"}, 32'(dmem_read), 32'd0);
    chk({nm, ".done.write"}, 32'(dmem_write), 32'd0);
    chk({nm, ".done.rdata"}, 32'(mem_rdata), 32'(exp_rdata));
    @(posedge clk);
    #1 req_valid = 1'b0;
    dmem_resp = 1'b0;
    #1;
    chk({nm, ".idle.done"}, 32'(mem_done), 32'd0);
    chk({nm, ".idle.stall"}, 32'(mem_stall), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_mem_read = 1'b0; req_mem_write = 1'b0;
    req_is_ldi = 1'b0; req_is_sti = 1'b0; req_byte_enable = 2'b00;
    req_address = '0; req_wdata = '0; dmem_resp = 1'b0; dmem_rdata = '0;
    exp_rdata = '0;
    #1;
    chk_quiet("reset", 1'b0);
    chk("reset.addr", 32'(dmem_address), 32'd0);
    chk("reset.be", 32'(dmem_byte_enable), 32'd0);
    chk("reset.rdata", 32'(mem_rdata), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_txn("ldr", 0, 16'h1003, 16'h0000, 2'b11, 2, 0, 16'hBEEF, 16'h0);
    run_txn("stb", 1, 16'h2001, 16'hAB00, 2'b10, 1, 0, 16'h0, 16'h0);
    run_txn("ldi", 2, 16'h3000, 16'h0000, 2'b11, 2, 3, 16'h4001, 16'h1234);
    run_txn("sti", 3, 16'h3000, 16'h00FF, 2'b01, 1, 2, 16'h5000, 16'h0);

    // Idle noise: spurious response, ADD-like valid instruction, invalid memory request.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dmem_resp = 1'b1;
      dmem_rdata = 16'($urandom);
      req_valid = (i != 2);
      req_mem_read = (i == 2); req_mem_write = (i == 2);
      req_is_ldi = (i == 2); req_is_sti = (i == 2);
      #1;
      chk_quiet($sformatf("idle_noise%0d", i), 1'b0);
      chk($sformatf("idle_noise%0d.rdata", i), 32'(mem_rdata), 32'(exp_rdata));
    end
    @(negedge clk);
    dmem_resp = 1'b0;
    req_valid = 1'b0;

    // Reset in the middle of the second LDI access.
    @(negedge clk);
    drive_req(2, 16'h3000, 16'h0, 2'b11);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    dmem_resp = 1'b1;
    dmem_rdata = 16'h6001;
    @(posedge clk);
    #1 dmem_resp = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mid.pre.read", 32'(dmem_read), 32'd1);
    chk("rst_mid.pre.addr", 32'(dmem_address), 32'h6000);
    rst = 1'b1;
    #1;
    exp_rdata = '0;
    chk_quiet("rst_mid", 1'b0);
    chk("rst_mid.rdata", 32'(mem_rdata), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_quiet("rst_mid.after", 1'b0);
    run_txn("ldr_after_rst", 0, 16'h0777, 16'h0, 2'b11, 1, 0, 16'hCAFE, 16'h0);

    for (int n = 0; n < 25; n++) begin
      run_txn($sformatf("rnd%0d", n), int'($urandom_range(0, 3)), 16'($urandom),
              16'($urandom), 2'($urandom_range(1, 3)), int'($urandom_range(1, 4)),
              int'($urandom_range(1, 4)), 16'($urandom), 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
